// File: rtl/axil_master_queued_pkg.sv
// axil_master_queued_pkg: shared state encodings, response codes and counter helpers
package axil_master_queued_pkg;
  localparam int CNT_W = 16;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/axil_cmd_fifo.sv
// axil_cmd_fifo: synchronous command FIFO with wrap-bit pointers and registered flags
module axil_cmd_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp, wp_n, rp_n;
  assign wp_n = wp + (AW+1)'(push && !full);
  assign rp_n = rp + (AW+1)'(pop && !empty);
  assign dout = mem[rp[AW-1:0]];
  // pointers and flags; full holds high through reset so upstream ready stays low until release
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      full <= 1'b1;
      empty <= 1'b1;
    end else begin
      wp <= wp_n;
      rp <= rp_n;
      empty <= wp_n == rp_n;
      full <= wp_n == {~rp_n[AW], rp_n[AW-1:0]};
    end
  // entry storage, written only when the push is actually accepted
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/axil_master_queued.sv
// axil_master_queued: AXI-Lite master with independent queued write and read command paths
module axil_master_queued
  import axil_master_queued_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] wr_strb,
  output logic                        wr_done,
  output logic [1:0]                  wr_error,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   rd_addr,
  output logic                        rd_done,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]                  rd_error,
  output logic [CNT_W-1:0]            wr_err_cnt,
  output logic [CNT_W-1:0]            rd_err_cnt,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,
  input  logic [1:0]                  m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                        m_axil_arvalid,
  input  logic                        m_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                  m_axil_rresp,
  input  logic                        m_axil_rvalid,
  output logic                        m_axil_rready
);
  localparam int WW = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + AXI_DATA_WIDTH/8;
  wr_state_t w_state;
  rd_state_t r_state;
  logic wf_full, wf_empty, wf_pop, rf_full, rf_empty, rf_pop;
  logic [WW-1:0] wf_dout;
  logic [AXI_ADDR_WIDTH-1:0] rf_dout;
  assign wr_ready = !wf_full;
  assign rd_ready = !rf_full;
  assign wf_pop = w_state == W_IDLE && !wf_empty;
  assign rf_pop = r_state == R_IDLE && !rf_empty;
  assign m_axil_bready = w_state == W_RESP;
  assign m_axil_rready = r_state == R_DATA;
  axil_cmd_fifo #(.W(WW), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk(aclk), .rst(areset), .push(wr_valid), .din({wr_addr, wr_data, wr_strb}),
    .pop(wf_pop), .dout(wf_dout), .full(wf_full), .empty(wf_empty)
  );
  axil_cmd_fifo #(.W(AXI_ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk(aclk), .rst(areset), .push(rd_valid), .din(rd_addr),
    .pop(rf_pop), .dout(rf_dout), .full(rf_full), .empty(rf_empty)
  );
  // write path: pop a command, drive AW and W together, then collect B
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      w_state <= W_IDLE;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid <= 1'b0;
      m_axil_awaddr <= '0;
      m_axil_wdata <= '0;
      m_axil_wstrb <= '0;
      wr_done <= 1'b0;
      wr_error <= RESP_OKAY;
      wr_err_cnt <= '0;
    end else begin
      wr_done <= 1'b0;
      case (w_state)
        W_IDLE: if (!wf_empty) begin
          w_state <= W_XFER;
          m_axil_awvalid <= 1'b1;
          m_axil_wvalid <= 1'b1;
          {m_axil_awaddr, m_axil_wdata, m_axil_wstrb} <= wf_dout;
        end
        W_XFER: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready) m_axil_wvalid <= 1'b0;
          if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) w_state <= W_RESP;
        end
        W_RESP: if (m_axil_bvalid) begin
          w_state <= W_IDLE;
          wr_done <= 1'b1;
          wr_error <= m_axil_bresp;
          if (m_axil_bresp != RESP_OKAY) wr_err_cnt <= sat_inc(wr_err_cnt);
        end
        default: w_state <= W_IDLE;
      endcase
    end
  // read path: pop a command, drive AR, then collect R
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_state <= R_IDLE;
      m_axil_arvalid <= 1'b0;
      m_axil_araddr <= '0;
      rd_done <= 1'b0;
      rd_data <= '0;
      rd_error <= RESP_OKAY;
      rd_err_cnt <= '0;
    end else begin
      rd_done <= 1'b0;
      case (r_state)
        R_IDLE: if (!rf_empty) begin
          r_state <= R_ADDR;
          m_axil_arvalid <= 1'b1;
          m_axil_araddr <= rf_dout;
        end
        R_ADDR: if (m_axil_arready) begin
          r_state <= R_DATA;
          m_axil_arvalid <= 1'b0;
        end
        R_DATA: if (m_axil_rvalid) begin
          r_state <= R_IDLE;
          rd_done <= 1'b1;
          rd_data <= m_axil_rdata;
          rd_error <= m_axil_rresp;
          if (m_axil_rresp != RESP_OKAY) rd_err_cnt <= sat_inc(rd_err_cnt);
        end
        default: r_state <= R_IDLE;
      endcase
    end
endmodule

// File: tb/tb_axil_master_queued.sv
// tb_axil_master_queued: scoreboard bench with a delay-configurable AXI-Lite slave model
module tb_axil_master_queued;
  import axil_master_queued_pkg::*;
  logic aclk = 0, areset = 1;
  logic wr_valid = 0, rd_valid = 0;
  logic [31:0] wr_addr = 0, wr_data = 0, rd_addr = 0;
  logic [3:0] wr_strb = 0;
  logic wr_ready, wr_done, rd_ready, rd_done;
  logic [1:0] wr_error, rd_error;
  logic [31:0] rd_data;
  logic [15:0] wr_err_cnt, rd_err_cnt;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0] bresp = 0, rresp = 0;
  logic [31:0] rdata = 0;
  int tests = 0, fails = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit rand_mode = 0;
  int wr_dones = 0, rd_dones = 0;
  logic [31:0] exp_aw_q[$], exp_ar_q[$];
  logic [35:0] exp_w_q[$];
  logic [1:0] bresp_q[$], wr_exp_q[$];
  logic [33:0] rsp_q[$], rd_exp_q[$];

  axil_master_queued dut (
    .aclk(aclk), .areset(areset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_done(wr_done), .wr_error(wr_error),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_data(rd_data), .rd_error(rd_error),
    .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  always #5 aclk = ~aclk;

  function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  // slave model: ready/valid delays, payload order checks, hold-while-valid checks
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit aw_ok, w_ok, ar_ok, b_hs, r_hs, p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_araddr;
    logic [35:0] p_w_pl;
    forever begin
      @(negedge aclk);
      if (areset) begin
        {awready, wready, bvalid, arready, rvalid} = '0;
        bresp = 0; rresp = 0; rdata = 0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        {aw_ok, w_ok, ar_ok, b_hs, r_hs, p_aw, p_w, p_ar} = '0;
        exp_aw_q.delete(); exp_w_q.delete(); bresp_q.delete(); exp_ar_q.delete(); rsp_q.delete();
      end else begin
        if (p_aw) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (p_w) chk("w_hold", {wvalid, wdata, wstrb}, {1'b1, p_w_pl});
        if (p_ar) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
        if (b_hs) begin
          bvalid = 0; b_hs = 0; aw_ok = 0; w_ok = 0; b_cnt = 0;
        end else if (aw_ok && w_ok) begin
          if (!bvalid && b_cnt >= b_dly) begin
            bvalid = 1;
            bresp = bresp_q.size() ? bresp_q.pop_front() : 2'b00;
          end
          b_cnt++;
          if (bvalid && bready) begin
            b_hs = 1;
            if (rand_mode) b_dly = $urandom_range(0, 3);
          end
        end
        if (r_hs) begin
          rvalid = 0; r_hs = 0; ar_ok = 0; r_cnt = 0;
        end else if (ar_ok) begin
          if (!rvalid && r_cnt >= r_dly) begin
            rvalid = 1;
            {rdata, rresp} = rsp_q.size() ? rsp_q.pop_front() : 34'h0;
          end
          r_cnt++;
          if (rvalid && rready) begin
            r_hs = 1;
            if (rand_mode) r_dly = $urandom_range(0, 3);
          end
        end
        if (awvalid && !aw_ok) begin awready = aw_cnt >= aw_dly; aw_cnt++; end
        else begin awready = 0; aw_cnt = 0; end
        if (wvalid && !w_ok) begin wready = w_cnt >= w_dly; w_cnt++; end
        else begin wready = 0; w_cnt = 0; end
        if (arvalid && !ar_ok) begin arready = ar_cnt >= ar_dly; ar_cnt++; end
        else begin arready = 0; ar_cnt = 0; end
        if (awvalid && awready) begin
          if (exp_aw_q.size() == 0) chk("aw_unexpected", 1, 0);
          else chk("aw_addr", awaddr, exp_aw_q.pop_front());
          aw_ok = 1;
          if (rand_mode) aw_dly = $urandom_range(0, 3);
        end
        if (wvalid && wready) begin
          if (exp_w_q.size() == 0) chk("w_unexpected", 1, 0);
          else chk("w_data_strb", {wdata, wstrb}, exp_w_q.pop_front());
          w_ok = 1;
          if (rand_mode) w_dly = $urandom_range(0, 3);
        end
        if (arvalid && arready) begin
          if (exp_ar_q.size() == 0) chk("ar_unexpected", 1, 0);
          else chk("ar_addr", araddr, exp_ar_q.pop_front());
          ar_ok = 1;
          if (rand_mode) ar_dly = $urandom_range(0, 3);
        end
        p_aw = awvalid && !awready; p_awaddr = awaddr;
        p_w = wvalid && !wready; p_w_pl = {wdata, wstrb};
        p_ar = arvalid && !arready; p_araddr = araddr;
      end
    end
  end

  // completion monitor: pops the scoreboard on each done pulse
  initial begin
    logic [15:0] wr_cnt_m, rd_cnt_m;
    logic [1:0] we;
    logic [33:0] re;
    wr_cnt_m = 0; rd_cnt_m = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        wr_exp_q.delete(); rd_exp_q.delete();
        wr_cnt_m = 0; rd_cnt_m = 0;
      end else begin
        if (wr_done) begin
          wr_dones++;
          if (wr_exp_q.size() == 0) chk("wr_done_unexpected", 1, 0);
          else begin
            we = wr_exp_q.pop_front();
            chk("wr_error", wr_error, we);
            if (we != RESP_OKAY && wr_cnt_m != 16'hFFFF) wr_cnt_m++;
            chk("wr_err_cnt", wr_err_cnt, wr_cnt_m);
          end
        end
        if (rd_done) begin
          rd_dones++;
          if (rd_exp_q.size() == 0) chk("rd_done_unexpected", 1, 0);
          else begin
            re = rd_exp_q.pop_front();
            chk("rd_data_error", {rd_data, rd_error}, re);
            if (re[1:0] != RESP_OKAY && rd_cnt_m != 16'hFFFF) rd_cnt_m++;
            chk("rd_err_cnt", rd_err_cnt, rd_cnt_m);
          end
        end
      end
    end
  end

  task automatic wr_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    exp_aw_q.push_back(a); exp_w_q.push_back({d, s}); bresp_q.push_back(r); wr_exp_q.push_back(r);
    wr_valid = 1; wr_addr = a; wr_data = d; wr_strb = s;
    for (int i = 0; i < 200 && !wr_ready; i++) @(negedge aclk);
    chk("wr_accept", wr_ready, 1);
    @(negedge aclk);
    wr_valid = 0;
  endtask

  task automatic rd_cmd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    exp_ar_q.push_back(a); rsp_q.push_back({d, r}); rd_exp_q.push_back({d, r});
    rd_valid = 1; rd_addr = a;
    for (int i = 0; i < 200 && !rd_ready; i++) @(negedge aclk);
    chk("rd_accept", rd_ready, 1);
    @(negedge aclk);
    rd_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (wr_exp_q.size() + rd_exp_q.size()) != 0; i++) @(negedge aclk);
    chk("drain", wr_exp_q.size() + rd_exp_q.size(), 0);
    @(negedge aclk);
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n;
    repeat (2) @(negedge aclk);
    chk("rst_ctrl", {awvalid, wvalid, arvalid, bready, rready, wr_done, rd_done, wr_ready, rd_ready}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_errors", {wr_error, rd_error}, 0);
    chk("rst_cnts", {wr_err_cnt, rd_err_cnt}, 0);
    areset = 0;
    @(negedge aclk);
    chk("ready_after_rst", {wr_ready, rd_ready}, 2'b11);
    // single write, AW accepted before W, OKAY
    aw_dly = 0; w_dly = 2; b_dly = 1;
    n = wr_dones;
    wr_cmd(32'h10, 32'hDEADBEEF, 4'hF, RESP_OKAY);
    chk("aw_lat_pop", awvalid, 0);
    @(negedge aclk);
    chk("aw_lat_valid", {awvalid, wvalid}, 2'b11);
    drain();
    chk("wr_done_count1", wr_dones - n, 1);
    chk("wr_err_cnt0", wr_err_cnt, 0);
    // single read returning SLVERR
    ar_dly = 1; r_dly = 2;
    n = rd_dones;
    rd_cmd(32'h20, 32'h12345678, RESP_SLVERR);
    drain();
    chk("rd_done_count1", rd_dones - n, 1);
    chk("rd_result", {rd_data, rd_error, rd_err_cnt}, {32'h12345678, 2'b10, 16'd1});
    // DECERR write and EXOKAY read both count as errors; read result held across a write
    wr_cmd(32'h14, 32'h0BADF00D, 4'h1, RESP_DECERR);
    drain();
    chk("rd_data_hold", {rd_data, rd_error}, {32'h12345678, 2'b10});
    rd_cmd(32'h24, 32'hCAFEF00D, RESP_EXOKAY);
    drain();
    chk("err_cnts", {wr_err_cnt, rd_err_cnt}, {16'd1, 16'd2});
    // five back-to-back writes with AW stalled: one in flight plus four queued fills the FIFO
    aw_dly = 1000; w_dly = 0; b_dly = 0;
    n = wr_dones;
    for (int i = 0; i < 5; i++) wr_cmd(32'h100 + 4 * i, 32'hA0000000 + i, i == 2 ? 4'h3 : 4'hF, RESP_OKAY);
    chk("wr_ready_full", {wr_ready, awvalid}, 2'b01);
    aw_dly = 0;
    drain();
    chk("wr_done_count5", wr_dones - n, 5);
    // concurrent traffic with random slave delays
    rand_mode = 1;
    fork
      for (int i = 0; i < 4; i++) wr_cmd(32'h200 + 8 * i, 32'h5000 + 3 * i, 4'hF, i == 1 ? RESP_SLVERR : RESP_OKAY);
      for (int j = 0; j < 4; j++) rd_cmd(32'h280 + 4 * j, 32'h7000 + 5 * j, RESP_OKAY);
    join
    drain();
    rand_mode = 0;
    chk("err_cnts_conc", {wr_err_cnt, rd_err_cnt}, {16'd2, 16'd2});
    // reset while a write is stalled on the bus
    aw_dly = 1000; w_dly = 1000;
    wr_cmd(32'h300, 32'h55AA55AA, 4'hF, RESP_OKAY);
    for (int i = 0; i < 20 && !awvalid; i++) @(negedge aclk);
    chk("awvalid_before_rst", awvalid, 1);
    #2 areset = 1;
    #1 chk("rst_async", {awvalid, wvalid, wr_ready, rd_ready}, 0);
    repeat (2) @(negedge aclk);
    areset = 0;
    aw_dly = 0; w_dly = 0;
    n = wr_dones;
    @(negedge aclk);
    chk("ready_after_rst2", {wr_ready, rd_ready}, 2'b11);
    repeat (10) @(negedge aclk);
    chk("no_reissue", {awvalid, wvalid, wr_dones - n}, 0);
    chk("cnts_after_rst", {wr_err_cnt, rd_err_cnt}, 0);
    wr_cmd(32'h400, 32'h13579BDF, 4'hC, RESP_SLVERR);
    drain();
    chk("recover_write", {wr_dones - n, wr_error, wr_err_cnt}, {32'd1, 2'b10, 16'd1});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axil_master_queued.md
AXIL_MASTER_QUEUED -- requirements
Module: axil_master_queued

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, data width in bits (32 or 64).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per command FIFO (power of 2, >=2).
REQ-004 SHALL have port aclk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port areset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports wr_valid in 1, wr_ready out 1, wr_addr in AXI_ADDR_WIDTH, wr_data in AXI_DATA_WIDTH, wr_strb in AXI_DATA_WIDTH/8: write command handshake.
REQ-007 SHALL have ports wr_done out 1 (completion pulse), wr_error out 2 (BRESP of completed write).
REQ-008 SHALL have ports rd_valid in 1, rd_ready out 1, rd_addr in AXI_ADDR_WIDTH: read command handshake.
REQ-009 SHALL have ports rd_done out 1, rd_data out AXI_DATA_WIDTH, rd_error out 2 (RRESP).
REQ-010 SHALL have ports wr_err_cnt out 16 and rd_err_cnt out 16: saturating non-OKAY response counters.
REQ-011 SHALL have full AXI-Lite master ports m_axil_aw*/w*/b*/ar*/r* (awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready), widths per parameters.

Function
REQ-012 SHALL accept a write command when wr_valid && wr_ready; wr_ready = !write FIFO full (no bypass when full, even if popping that cycle).
REQ-013 SHALL accept a read command when rd_valid && rd_ready; rd_ready = !read FIFO full.
REQ-014 SHALL run write FSM IDLE -> XFER -> RESP -> IDLE; leave IDLE when write FIFO non-empty, popping head entry.
REQ-015 SHALL in XFER assert awvalid and wvalid together, registered, first asserted the cycle after the pop; each drops independently on its own handshake; go to RESP once both complete (either order, or same cycle).
REQ-016 SHALL in RESP hold bready=1; on bvalid&&bready pulse wr_done for exactly one cycle next cycle with wr_error=bresp, return to IDLE.
REQ-017 SHALL run read FSM IDLE -> ADDR -> DATA -> IDLE: arvalid registered in ADDR until arready; rready=1 in DATA; on rvalid&&rready pulse rd_done one cycle next cycle with rd_data=rdata, rd_error=rresp.
REQ-018 SHALL hold rd_data and wr/rd_error stable from done pulse until next done pulse.
REQ-019 SHALL keep addr/data/strb stable while the corresponding valid is high (AXI rule: no valid withdrawal).
REQ-020 SHALL run write and read paths fully independently; one outstanding transaction per path.
REQ-021 SHALL increment wr_err_cnt (rd_err_cnt) on each completion with resp != 2'b00; saturate at 16'hFFFF.
REQ-022 SHALL issue commands strictly in acceptance order per path; FIFO pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
REQ-023 SHALL accept a push into an empty FIFO and an FSM pop in the same cycle only after the push has landed (minimum command-to-valid latency 2 cycles).

Reset
REQ-024 SHALL on areset asynchronously force FSMs to IDLE, empty both FIFOs, counters to 0, all valid/ready/done outputs 0, rd_data 0, errors 2'b00.
REQ-025 SHALL, on reset mid-transaction, abandon it without completion pulse or counter update.

Structure
REQ-026 SHALL place FSM state enums, resp encodings (OKAY/EXOKAY/SLVERR/DECERR) and counter width in package axil_master_queued_pkg.
REQ-027 SHALL instantiate sub-module axil_cmd_fifo (parametrised width/depth, sync, registered flags) twice: write entry {addr,data,strb}, read entry {addr}.

Verification
REQ-028 SHALL cover: write 0x10/0xDEADBEEF/strb 0xF, awready before wready, bresp OKAY -> one wr_done, wr_error 00, wr_err_cnt 0.
REQ-029 SHALL cover: 5 back-to-back writes, FIFO_DEPTH 4, slave stalls awready -> wr_ready low after 4, issue order preserved, 5 wr_done pulses.
REQ-030 SHALL cover: read 0x20, rdata 0x12345678, rresp SLVERR -> rd_done, rd_data 0x12345678, rd_error 10, rd_err_cnt 1.
REQ-031 SHALL cover: concurrent write and read with random ready delays -> both complete, no protocol violations (valid held, payload stable).
REQ-032 SHALL cover: areset asserted while awvalid high -> awvalid 0 immediately, no wr_done, FIFOs empty, wr_ready 1 after release.
